// File: rtl/fetch_buffer_if.sv
// Handshake bundle between I-fetch (enqueue side), the fetch buffer and pre-decode/decode (dequeue side).
// The master is the surrounding pipeline, the slave is the buffer itself.
interface fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_ready;
    logic            flush;
    logic [CW-1:0]   count;
    logic            almost_full;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, count, almost_full
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count, almost_full
    );
endinterface

// File: rtl/fetch_buffer.sv
// In-order FIFO of {pc, inst} pairs between instruction fetch and decode.
// Every output is decoded from registered state; flush empties the buffer in a single cycle.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_buffer_if.slave fb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic   not_full;
    logic   not_empty;
    logic   enq;
    logic   deq;
    entry_t head_entry;

    assign not_full   = (count_q != FULL_CNT);
    assign not_empty  = (count_q != '0);
    assign head_entry = mem_q[head_q];

    // A dequeue in the same cycle never frees a slot for a full buffer: in_ready uses count_q only.
    always_comb begin
        enq     = fb.in_valid && not_full && !fb.flush;
        deq     = not_empty && fb.out_ready && !fb.flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (fb.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                mem_d[tail_q] = '{pc: fb.in_pc, inst: fb.in_inst};
                tail_d        = tail_q + AW'(1);
            end
            if (deq) begin
                head_d = head_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; empty slots are masked by count_q.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign fb.in_ready    = not_full;
    assign fb.out_valid   = not_empty;
    assign fb.out_pc      = not_empty ? head_entry.pc   : '0;
    assign fb.out_inst    = not_empty ? head_entry.inst : '0;
    assign fb.count       = count_q;
    assign fb.almost_full = (count_q >= AF_CNT);
endmodule
